// File: rtl/shift_add_mult4.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier driving an external fulladd4b.
// Optional: define MULT_ZERO_SKIP_EN to finish zero-operand requests in one cycle.
module shift_add_mult4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;

    // The adder sees only registered values, so there is no combinational path from inputs.
    assign add_a   = acc_hi;
    assign add_b   = acc_lo[0] ? m_reg : '0;
    assign add_cin = 1'b0;

    // Carry-out lands in the new MSB so a full 2*WIDTH product is never truncated.
    assign acc_next = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        // NOTE: every register here uses <= so all updates see pre-edge values, regardless of order.
        if (!reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_reg   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg  <= mcand;
                        acc_hi <= '0;
                        acc_lo <= mplier;
                        cnt    <= '0;
`ifdef MULT_ZERO_SKIP_EN
                        if ((mcand == '0) || (mplier == '0)) begin
                            product <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
`else
                        busy  <= 1'b1;
                        state <= ST_RUN;
`endif
                    end
                end

                ST_RUN: begin
                    {acc_hi, acc_lo} <= acc_next;
                    cnt              <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        // Capture the post-iteration value so product is valid with done.
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4 with a behavioural 4-bit adder at the parent level.
// Expected products go into a scoreboard queue at acceptance and are checked when done pulses.
module tb_shift_add_mult4;

    localparam int WIDTH = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*WIDTH-1:0] sb[$];
    logic saw_cout;

    shift_add_mult4 #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    // Stand-in for fulladd4b.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else                check("product", 32'(product), 32'(sb.pop_front()));
        end
    end

    // Drive a request; returns just after the acceptance edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit keep);
        @(negedge clock);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clock);
        sb.push_back(8'(a) * 8'(b));
        #1;
        if (!keep) start = 1'b0;
    endtask

    // Called right after an acceptance edge; measures edges until done and busy cycles.
    task automatic wait_done(input string tag, input int exp_edges, input int exp_busy);
        int   busy_cnt = 0;
        int   k        = 0;
        logic cin_seen = 1'b0;
        bit   got      = 1'b0;
        saw_cout = 1'b0;
        while (k < 30 && !got) begin
            @(negedge clock);
            k++;
            if (busy) busy_cnt++;
            if (add_cin) cin_seen = 1'b1;
            if (busy && add_b != 0 && add_cout) saw_cout = 1'b1;
            if (done) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(k - 1), 32'(exp_edges));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_add_cin"}, 32'(cin_seen), 32'd0);
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2*WIDTH-1:0] held;
        int pulses;
        reset  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_add_cin", 32'(add_cin), 32'd0);
        reset = 1'b1;

        start_op(4'd12, 4'd3, 1'b0);
        wait_done("m12x3", 4, 4);

        start_op(4'd15, 4'd15, 1'b0);
        wait_done("m15x15", 4, 4);
        check("m15x15_carry_seen", 32'(saw_cout), 32'd1);

        // start stays high through RUN/DONE with new operands; only the IDLE edge accepts them
        start_op(4'd13, 4'd11, 1'b1);
        mcand  = 4'd2;
        mplier = 4'd7;
        wait_done("m13x11", 4, 4);
        @(posedge clock);
        sb.push_back(8'd14);
        #1;
        start = 1'b0;
        wait_done("m2x7", 4, 4);

        start_op(4'd0, 4'd15, 1'b0);
`ifdef MULT_ZERO_SKIP_EN
        wait_done("m0x15", 0, 0);
`else
        wait_done("m0x15", 4, 4);
`endif

        // Reset lands on the second RUN edge
        start_op(4'd9, 4'd9, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        sb.delete();
        reset  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        start_op(4'd5, 4'd6, 1'b0);
        wait_done("m5x6", 4, 4);

        held = 8'd30;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (product !== held || busy !== 1'b0 || done !== 1'b0) pulses++;
        end
        check("idle_hold_bad_cycles", 32'(pulses), 32'd0);
        check("idle_hold_product", 32'(product), 32'(held));

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
